// File: rtl/prog_sequencer.sv
// Program sequencer: launches one of three fixed PC-range programs on the fetch unit,
// watches for the end PC or a cycle timeout, and reports completion, error or abort.
module prog_sequencer #(
    parameter logic [15:0] PROG0_START = 16'd0,
    parameter logic [15:0] PROG0_END   = 16'd123,
    parameter logic [15:0] PROG1_START = 16'd124,
    parameter logic [15:0] PROG1_END   = 16'd300,
    parameter logic [15:0] PROG2_START = 16'd301,
    parameter logic [15:0] PROG2_END   = 16'd511,
    parameter logic [15:0] TIMEOUT     = 16'd4000
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [1:0]  Prog_Id,
    input  logic        Abort,
    input  logic [15:0] PC,
    output logic        Init,
    output logic [15:0] Start_PC,
    output logic        Run,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic        Timed_Out,
    output logic [1:0]  Active_Id,
    output logic [15:0] Cycle_Count
);

    // One-hot encoding so each strobe is a single flop bit and cannot glitch.
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        LOAD   = 5'b00010,
        RUN    = 5'b00100,
        FINISH = 5'b01000,
        ERR    = 5'b10000
    } state_t;

    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    state_t      state_q, state_d;
    logic [4:0]  state_bits;
    logic [1:0]  active_id_d;
    logic [15:0] start_pc_d, cycle_count_d, end_pc;
    logic        timed_out_d;

    function automatic logic [15:0] prog_start(input logic [1:0] id);
        case (id)
            2'd0:    prog_start = PROG0_START;
            2'd1:    prog_start = PROG1_START;
            default: prog_start = PROG2_START;
        endcase
    endfunction

    always_comb begin
        case (Active_Id)
            2'd0:    end_pc = PROG0_END;
            2'd1:    end_pc = PROG1_END;
            default: end_pc = PROG2_END;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        active_id_d   = Active_Id;
        start_pc_d    = Start_PC;
        cycle_count_d = Cycle_Count;
        timed_out_d   = Timed_Out;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Prog_Id == 2'd3) begin
                        state_d = ERR;
                    end else begin
                        state_d     = LOAD;
                        active_id_d = Prog_Id;
                        start_pc_d  = prog_start(Prog_Id);
                        timed_out_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (Abort) begin
                    state_d = IDLE;
                end else begin
                    state_d       = RUN;
                    cycle_count_d = 16'd0;
                end
            end
            RUN: begin
                // The current cycle is a RUN cycle, so it is counted whatever comes next.
                if (Cycle_Count != 16'hFFFF)
                    cycle_count_d = Cycle_Count + 16'd1;
                if (Abort) begin
                    state_d = IDLE;
                end else if (PC == end_pc) begin
                    state_d = FINISH;
                end else if (Cycle_Count == TO_LAST) begin
                    state_d     = ERR;
                    timed_out_d = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            Active_Id   <= 2'd0;
            Start_PC    <= 16'd0;
            Cycle_Count <= 16'd0;
            Timed_Out   <= 1'b0;
        end else begin
            state_q     <= state_d;
            Active_Id   <= active_id_d;
            Start_PC    <= start_pc_d;
            Cycle_Count <= cycle_count_d;
            Timed_Out   <= timed_out_d;
        end
    end

    assign state_bits = state_q;
    assign Init  = state_bits[1];
    assign Run   = state_bits[2];
    assign Done  = state_bits[3];
    assign Error = state_bits[4];
    assign Busy  = state_bits[1] | state_bits[2];

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PROG0_START, default 16'd0, meaning program 0 first PC.
REQ-002 SHALL have parameter PROG0_END, default 16'd123, meaning program 0 last PC.
REQ-003 SHALL have parameter PROG1_START, default 16'd124, meaning program 1 first PC.
REQ-004 SHALL have parameter PROG1_END, default 16'd300, meaning program 1 last PC.
REQ-005 SHALL have parameter PROG2_START, default 16'd301, meaning program 2 first PC.
REQ-006 SHALL have parameter PROG2_END, default 16'd511, meaning program 2 last PC.
REQ-007 SHALL have parameter TIMEOUT, default 16'd4000, meaning the maximum number of RUN cycles per program.
REQ-008 SHALL have ports: CLK  in  1  sole clock, rising-edge; Reset_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have ports: Start  in  1  run request; Prog_Id  in  2  requested program (0-2 valid); Abort  in  1  cancel the current run.
REQ-010 SHALL have port: PC  in  16  program counter from the fetch unit.
REQ-011 SHALL have ports: Init  out  1  fetch-unit load strobe; Start_PC  out  16  PC value to load; Run  out  1  fetch enable.
REQ-012 SHALL have ports: Busy  out  1  run in progress; Done  out  1  completion pulse; Error  out  1  error pulse; Timed_Out  out  1  sticky timeout flag.
REQ-013 SHALL have ports: Active_Id  out  2  program being or last run; Cycle_Count  out  16  RUN cycles of the last or current run.

Function
REQ-014 SHALL implement the states IDLE, LOAD, RUN, FINISH and ERR in a single registered state machine.
REQ-015 IDLE: when Start=1 and Prog_Id<=2, the next state SHALL be LOAD, with Active_Id<=Prog_Id and Start_PC<=PROGn_START.
REQ-016 IDLE: when Start=1 and Prog_Id==3, the next state SHALL be ERR, with Active_Id, Start_PC and Cycle_Count unchanged.
REQ-017 Start SHALL be ignored in every state other than IDLE; no queuing.
REQ-018 LOAD SHALL last exactly 1 cycle: Init=1, Busy=1, Run=0, Cycle_Count<=0, then RUN.
REQ-019 RUN: Run=1 and Busy=1; Cycle_Count SHALL increment by 1 per RUN cycle and saturate at 16'hFFFF.
REQ-020 RUN: when PC==PROGn_END of Active_Id in a cycle, the next state SHALL be FINISH; the count SHALL include that cycle.
REQ-021 RUN: when Cycle_Count==TIMEOUT-1 and the end PC is not seen, the next state SHALL be ERR and Timed_Out<=1.
REQ-022 If the end PC and the timeout occur in the same cycle, the end-PC match SHALL win (FINISH, no timeout).
REQ-023 FINISH SHALL last exactly 1 cycle: Done=1, Run=0, Busy=0, then IDLE.
REQ-024 ERR SHALL last exactly 1 cycle: Error=1, Run=0, Busy=0, then IDLE.
REQ-025 Abort=1 in LOAD or RUN SHALL force the next state to IDLE, with no Done and no Error, and Cycle_Count held.
REQ-026 Abort SHALL take priority over the end-PC match and the timeout.
REQ-027 Abort SHALL be ignored in IDLE, FINISH and ERR.
REQ-028 Timed_Out SHALL clear only on reset or on acceptance of a new valid Start.
REQ-029 Init, Run, Done and Error SHALL be decoded from the registered state only, glitch-free and never asserted together.
REQ-030 Start_PC and Active_Id SHALL hold their values outside LOAD and RUN.
REQ-031 Back-to-back operation: a Start asserted in the cycle after Done SHALL be accepted, with LOAD two cycles after FINISH.

Reset
REQ-032 Reset_n=0 SHALL asynchronously force state IDLE and set Init=0, Run=0, Busy=0, Done=0, Error=0, Timed_Out=0, Active_Id=0, Start_PC=16'd0 and Cycle_Count=0.
REQ-033 Reset asserted mid-RUN SHALL abort the run without a Done pulse; the first Start after Reset_n rises SHALL be sampled at the next rising edge.

Verification
REQ-034 The bench SHALL cover: Start with Prog_Id=1 -> Init pulse 1 cycle with Start_PC=124, Run=1, PC driven 124..300 -> Done 1 cycle, Cycle_Count=177.
REQ-035 The bench SHALL cover: Start with Prog_Id=3 -> Error 1 cycle, no Init, Busy stays 0, Timed_Out=0.
REQ-036 The bench SHALL cover: Prog_Id=0 with PC stuck at 5 -> ERR after 4000 RUN cycles, Timed_Out=1, Cycle_Count=4000; a next valid Start then clears Timed_Out.
REQ-037 The bench SHALL cover: Abort in the 10th RUN cycle -> IDLE next, no Done/Error, Cycle_Count=10.
REQ-038 The bench SHALL cover: PC==123 in the same cycle as the timeout boundary (TIMEOUT=124) -> Done, Timed_Out=0.
REQ-039 The bench SHALL cover: Reset_n pulsed low mid-RUN, asynchronously to CLK -> all outputs at reset values immediately, then Start with Prog_Id=2 -> Start_PC=301.
